// File: rtl/uart_rv.sv
// uart_rv: full-duplex 8N1 UART with ready/valid byte ports.
// Define UART_PARITY_EN for an 11-bit frame with an even parity bit.
module uart_rv #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [3:0] TX_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    tx_state_t               tx_state;
    logic [FRAME_BITS-2:0]   tx_shift;
    logic [FRAME_BITS-1:0]   tx_frame;
    logic [3:0]              tx_bit;
    logic [CW-1:0]           tx_cyc;

    rx_state_t               rx_state;
    logic                    rx_s1;
    logic                    rx_s2;
    logic [CW-1:0]           rx_cyc;
    logic [2:0]              rx_bit;
    logic [7:0]              rx_shift;
`ifdef UART_PARITY_EN
    logic                    rx_par_ok;
`endif

    always_comb begin
`ifdef UART_PARITY_EN
        tx_frame = {1'b1, ^data_in, data_in, 1'b0};
`else
        tx_frame = {1'b1, data_in, 1'b0};
`endif
    end

    // Bit 0 of the frame goes straight to the line; the rest waits in tx_shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            tx_shift      <= '1;
            tx_bit        <= '0;
            tx_cyc        <= '0;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (data_in_valid) begin
                        tx_shift      <= tx_frame[FRAME_BITS-1:1];
                        serial_out    <= tx_frame[0];
                        data_in_ready <= 1'b0;
                        tx_bit        <= '0;
                        tx_cyc        <= '0;
                        tx_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_cyc == SYM_LAST) begin
                        tx_cyc <= '0;
                        if (tx_bit == TX_LAST) begin
                            serial_out    <= 1'b1;
                            data_in_ready <= 1'b1;
                            tx_state      <= TX_IDLE;
                        end else begin
                            tx_bit     <= tx_bit + 4'd1;
                            serial_out <= tx_shift[0];
                            tx_shift   <= {1'b1, tx_shift[FRAME_BITS-2:1]};
                        end
                    end else begin
                        tx_cyc <= tx_cyc + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= serial_in;
            rx_s2 <= rx_s1;
        end
    end

    // A consume clears valid unless a new byte lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state       <= RX_IDLE;
            rx_cyc         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok      <= 1'b0;
`endif
        end else begin
            if (data_out_ready)
                data_out_valid <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    rx_cyc <= '0;
                    if (!rx_s2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cyc == SMP_LAST) begin
                        rx_cyc   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cyc <= rx_cyc + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cyc == SYM_LAST) begin
                        rx_cyc   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cyc <= rx_cyc + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_cyc == SYM_LAST) begin
                        rx_cyc    <= '0;
                        rx_par_ok <= (rx_s2 == ^rx_shift);
                        rx_state  <= RX_STOP;
                    end else begin
                        rx_cyc <= rx_cyc + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cyc == SYM_LAST) begin
                        rx_cyc   <= '0;
                        rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_s2 && rx_par_ok) begin
`else
                        if (rx_s2) begin
`endif
                            data_out       <= rx_shift;
                            data_out_valid <= 1'b1;
                        end
                    end else begin
                        rx_cyc <= rx_cyc + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rv.sv
// tb_uart_rv: default-rate TX/loopback checks plus a fast-rate pair
// driven from a vector table and a byte scoreboard.
module tb_uart_rv;

    localparam int SET  = 1085;
    localparam int FSET = 16;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a_din, a_dout, b_din, b_dout;
    logic       a_vld, a_rdy, a_ov, a_ordy, a_sin, a_sout;
    logic       b_vld, b_rdy, b_ov, b_ordy, b_sout;
    logic [7:0] c_din, c_dout, d_din, d_dout;
    logic       c_vld, c_rdy, c_ov, c_ordy, c_sin, c_sout;
    logic       d_vld, d_rdy, d_ov, d_ordy, d_sin, d_sout;
    logic       force_en, force_val;

    assign d_sin = force_en ? force_val : c_sout;

    uart_rv u_a (
        .clk(clk), .reset(rst),
        .data_in(a_din), .data_in_valid(a_vld), .data_in_ready(a_rdy),
        .data_out(a_dout), .data_out_valid(a_ov), .data_out_ready(a_ordy),
        .serial_in(a_sin), .serial_out(a_sout)
    );

    uart_rv u_b (
        .clk(clk), .reset(rst),
        .data_in(b_din), .data_in_valid(b_vld), .data_in_ready(b_rdy),
        .data_out(b_dout), .data_out_valid(b_ov), .data_out_ready(b_ordy),
        .serial_in(a_sout), .serial_out(b_sout)
    );

    uart_rv #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000)) u_c (
        .clk(clk), .reset(rst),
        .data_in(c_din), .data_in_valid(c_vld), .data_in_ready(c_rdy),
        .data_out(c_dout), .data_out_valid(c_ov), .data_out_ready(c_ordy),
        .serial_in(c_sin), .serial_out(c_sout)
    );

    uart_rv #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000)) u_d (
        .clk(clk), .reset(rst),
        .data_in(d_din), .data_in_valid(d_vld), .data_in_ready(d_rdy),
        .data_out(d_dout), .data_out_valid(d_ov), .data_out_ready(d_ordy),
        .serial_in(d_sin), .serial_out(d_sout)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    task automatic send_c(input logic [7:0] b, input logic [7:0] exp,
                          input bit push);
        int n;
        n = 0;
        @(negedge clk);
        c_din = b;
        c_vld = 1'b1;
        while (!c_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", c_rdy, 1);
        @(posedge clk);
        if (push) sb.push_back(exp);
        #1 c_vld = 1'b0;
    endtask

    task automatic recv_d(input string name);
        int n;
        logic [7:0] exp;
        n = 0;
        @(negedge clk);
        while (!d_ov && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, d_ov, 1);
        chk({name, "_sb_nonempty"}, sb.size() > 0, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        chk(name, d_dout, exp);
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        chk({name, "_clr"}, d_ov, 0);
    endtask

    task automatic drive_d(input logic [7:0] b, input logic stopv);
        logic [10:0] bits;
        bits = frame_of(b);
        bits[NB-1] = stopv;
        force_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            force_val = bits[i];
            repeat (FSET) @(negedge clk);
        end
        force_val = 1'b1;
        repeat (3 * FSET) @(negedge clk);
        force_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bit_err[11];
        int rdy_err;
        int bvalid_at;
        int n;
        int t1;
        int t2;
        logic [10:0] fr;

        rst = 1'b1;
        a_din = '0; a_vld = 1'b0; a_ordy = 1'b0; a_sin = 1'b1;
        b_din = '0; b_vld = 1'b0; b_ordy = 1'b0;
        c_din = '0; c_vld = 1'b0; c_ordy = 1'b0; c_sin = 1'b1;
        d_din = '0; d_vld = 1'b0; d_ordy = 1'b0;
        force_en = 1'b0; force_val = 1'b1;
        t1 = 0; t2 = 0; n = 0;

        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'hFF, 8'hFF};
        vecs[2] = '{8'h59, 8'h59};
        vecs[3] = '{8'hA5, 8'hA5};
        vecs[4] = '{8'h3C, 8'h3C};
        vecs[5] = '{8'h81, 8'h81};
        vecs[6] = '{8'h7E, 8'h7E};
        vecs[7] = '{8'h01, 8'h01};

        repeat (50) @(negedge clk);
        chk("rst_serial_out", a_sout, 1);
        chk("rst_in_ready", a_rdy, 1);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_data_out", a_dout, 0);
        chk("rst_fast_valid", d_ov, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // TX waveform of 0x59 at the default rate, received by u_b
        fr = frame_of(8'h59);
        for (int i = 0; i < 11; i++) bit_err[i] = 0;
        rdy_err = 0;
        bvalid_at = -1;
        a_din = 8'h59;
        a_vld = 1'b1;
        @(posedge clk);
        #1 a_vld = 1'b0;
        for (int k = 0; k < NB * SET; k++) begin
            @(negedge clk);
            if (a_sout !== fr[k / SET]) bit_err[k / SET]++;
            if (a_rdy !== 1'b0) rdy_err++;
            if (b_ov && bvalid_at < 0) bvalid_at = k;
        end
        for (int i = 0; i < NB; i++)
            chk($sformatf("tx_bit%0d", i), bit_err[i], 0);
        chk("tx_ready_low", rdy_err, 0);
        @(negedge clk);
        chk("tx_ready_back", a_rdy, 1);
        chk("tx_idle_line", a_sout, 1);
        chk("rx_latency", (bvalid_at >= (NB - 1) * SET + SET / 2 - 100)
                          && (bvalid_at <= NB * SET + 50), 1);
        chk("rx_byte_59", b_dout, 8'h59);
        repeat (20) @(negedge clk);
        chk("rx_hold_valid", b_ov, 1);
        chk("rx_hold_data", b_dout, 8'h59);
        b_ordy = 1'b1;
        @(negedge clk);
        b_ordy = 1'b0;
        chk("rx_consume_clr", b_ov, 0);

        // Reset in the middle of a frame
        a_din = 8'h00;
        a_vld = 1'b1;
        @(posedge clk);
        #1 a_vld = 1'b0;
        repeat (3 * SET) @(negedge clk);
        chk("midtx_line_low", a_sout, 0);
        chk("midtx_busy", a_rdy, 0);
        #2 rst = 1'b1;
        #1;
        chk("midtx_rst_line", a_sout, 1);
        chk("midtx_rst_ready", a_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midtx_no_partial", b_ov, 0);

        // Table of bytes through the fast pair
        for (int i = 0; i < 8; i++) begin
            send_c(vecs[i].din, vecs[i].exp, 1'b1);
            recv_d($sformatf("vec%0d", i));
        end

        // Back-to-back with valid held high
        fork
            begin
                @(negedge clk);
                c_din = 8'h00;
                c_vld = 1'b1;
                n = 0;
                while (!c_rdy && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1 t1 = cyc;
                sb.push_back(8'h00);
                c_din = 8'hFF;
                n = 0;
                @(negedge clk);
                while (!c_rdy && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_ready", c_rdy, 1);
                @(posedge clk);
                #1 t2 = cyc;
                sb.push_back(8'hFF);
                c_vld = 1'b0;
            end
            begin
                recv_d("b2b_first");
                recv_d("b2b_second");
            end
        join
        chk("b2b_spacing", t2 - t1, NB * FSET + 1);

        // Short low glitch, then a real frame
        @(negedge clk);
        force_val = 1'b0;
        force_en = 1'b1;
        repeat (4) @(negedge clk);
        force_val = 1'b1;
        repeat (3 * FSET) @(negedge clk);
        chk("glitch_no_byte", d_ov, 0);
        force_en = 1'b0;
        send_c(8'hA5, 8'hA5, 1'b1);
        recv_d("after_glitch");

        // Framing error dropped; same byte with a good stop bit accepted
        drive_d(8'h3C, 1'b0);
        chk("framing_drop", d_ov, 0);
        sb.push_back(8'h3C);
        drive_d(8'h3C, 1'b1);
        chk("forced_good_valid", d_ov, 1);
        recv_d("forced_good");

        // Overrun: newest byte wins
        send_c(8'h11, 8'h11, 1'b0);
        repeat (NB * FSET + 20) @(negedge clk);
        chk("ovr_first_valid", d_ov, 1);
        chk("ovr_first_data", d_dout, 8'h11);
        send_c(8'h22, 8'h22, 1'b0);
        repeat (NB * FSET + 20) @(negedge clk);
        chk("ovr_second_valid", d_ov, 1);
        chk("ovr_second_data", d_dout, 8'h22);
        sb.push_back(8'h22);
        recv_d("ovr_drain");

        chk("sb_empty_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rv.md
Name: uart_rv

Overview:
- Full-duplex 8N1 UART with ready/valid byte interfaces on the parallel side and one TX line plus one RX line on the serial side.
- Used in two places:
  - on-chip, inside the memory-mapped IO block of the CPU;
  - off-chip, as the bench/host-side peer.
- Transmitter and receiver are independent and can run simultaneously.

Parameters:
- CLOCK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division; 1085 at defaults). SAMPLE_TIME = SYMBOL_EDGE_TIME/2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_in_valid  in  1  data_in holds a byte to send.
- data_in_ready  out  1  transmitter idle; can accept a byte.
- data_out  out  8  last received byte.
- data_out_valid  out  1  data_out holds an unconsumed byte.
- data_out_ready  in  1  consumer takes data_out.
- serial_in  in  1  RX line, idle high.
- serial_out  out  1  TX line, idle high.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; it is fixed and not configurable.
- Reset values:
  - serial_out=1, data_in_ready=1, data_out_valid=0, data_out=0.
  - All counters=0; both FSMs in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is delivered.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts SYMBOL_EDGE_TIME cycles.
- TX handshake:
  - A byte is accepted on a clk edge where data_in_valid && data_in_ready. The byte is latched into a shift register.
  - data_in_ready drops the cycle after acceptance.
  - serial_out drives the start bit from the cycle after acceptance.
  - data_in_ready rises again one cycle after the stop bit's SYMBOL_EDGE_TIME elapses. This gives back-to-back frames with no idle gap.
  - data_in is ignored while data_in_ready=0.
- TX FSM:
  - IDLE → SEND on handshake.
  - SEND shifts 10 bits using a bit counter (0..9) and a cycle counter (0..SYMBOL_EDGE_TIME-1).
  - SEND → IDLE after bit 9.
- RX synchronisation: serial_in passes through a 2-flop synchroniser before use.
- RX FSM:
  - IDLE: wait for synchronised serial_in = 0, then go to START.
  - START: sample at SAMPLE_TIME.
    - If the line is 1, it was a glitch; return to IDLE.
    - Otherwise go to DATA.
  - DATA: sample each data bit at its mid-point (SYMBOL_EDGE_TIME after the previous sample). Shift LSB first.
  - STOP: sample the stop bit at its mid-point.
    - If 1: load data_out and set data_out_valid on the next edge.
    - If 0 (framing error): discard the byte; valid is unchanged.
    - Then return to IDLE. The receiver is re-armed for the next start edge within the stop bit.
- RX output handshake:
  - data_out_valid stays high and data_out stays stable until a clk edge with data_out_ready=1. Valid clears on that edge.
- Overrun: a new good frame completing while data_out_valid=1 overwrites data_out, and valid stays 1. The latest byte wins and no error flag is raised.
- Simultaneous events:
  - A consume (data_out_ready) on the same edge as a new frame completion leaves valid=1 with the new byte.
  - TX and RX are fully concurrent.
- Counters are wide enough for SYMBOL_EDGE_TIME ($clog2). Counter arithmetic is unsigned and never wraps mid-bit.

Optional Feature:
- UART_PARITY_EN: when defined, both sides use an 11-bit frame with an even-parity bit after the data bits (start, D0..D7, P, stop).
  - TX sends P = ^data.
  - RX discards any byte whose received parity mismatches ^data, in the same way as a framing error.
- Without the macro: plain 8N1 as above; no parity logic is synthesized.

Test Plan:
- Reset: hold reset 50 cycles → serial_out=1, data_in_ready=1, data_out_valid=0. Assert reset mid-TX → serial_out=1 within the same cycle (asynchronous).
- TX 0x59, default parameters:
  - Pulse data_in_valid for 1 cycle.
  - serial_out sequence, each bit held 1085 cycles: 0,1,0,0,1,1,0,1,0,1.
  - data_in_ready low for 10850 cycles, then high.
- Loop two instances (A serial_out→B serial_in), send 0x59:
  - B data_out=0x59, data_out_valid=1 about 10,300–10,900 cycles after the handshake.
  - Valid held until data_out_ready is pulsed, then 0 the next cycle.
- Back-to-back: send 0x00 then 0xFF with data_in_valid held high → two contiguous frames with no idle gap; receiver delivers 0x00 then 0xFF.
- Glitch: drive serial_in low for 200 cycles, then high → no byte delivered; RX returns to IDLE. A following frame of 0xA5 is received correctly.
- Framing error and overrun:
  - Frame 0x3C with stop bit forced 0 → no data_out_valid.
  - Two good frames (0x11, 0x22) with no consume → data_out=0x22, valid=1.
